// File: rtl/matrix_pkg.sv
// Shared types and constants for the 8x8 RGB LED matrix display stage.
package matrix_pkg;

   localparam int unsigned NUM_ROWS = 8;
   localparam int unsigned NUM_BANKS = 2;

   typedef logic [2:0] row_t;
   typedef logic [7:0] col_t;

   typedef struct packed {
      col_t r;
      col_t g;
      col_t b;
   } rgb_row_t;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } commit_state_t;

   localparam col_t COL_OFF  = 8'hFF;
   localparam logic COMM_EN  = 1'b1;
   localparam row_t LAST_ROW = 3'd7;

endpackage

// File: rtl/scan_prescaler.sv
// Row dwell prescaler: counts 0..SCAN_DIV-1 and flags the terminal count.
module scan_prescaler #(
   parameter int unsigned SCAN_DIV = 50000,
   localparam int unsigned CW = $clog2(SCAN_DIV)
) (
   input  logic          CLK,
   input  logic          reset,
   output logic          tick_c,
   output logic [CW-1:0] count
);

   assign tick_c = (count == CW'(SCAN_DIV - 1));

   always_ff @(posedge CLK) begin
      if (!reset)      count <= '0;
      else if (tick_c) count <= '0;
      else             count <= count + CW'(1);
   end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 RGB matrix scanner with frame-boundary commit.
// Define SCAN_BLANK_EN to blank the columns for BLANK_CYCLES at each row start.
module led_matrix_scanner
   import matrix_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 64
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_r,
   input  logic [7:0] wr_g,
   input  logic [7:0] wr_b,
   input  logic       commit,
   output logic       busy,
   output logic       frame_start,
   output logic [7:0] D_R,
   output logic [7:0] D_G,
   output logic [7:0] D_B,
   output logic [3:0] COMM
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
`ifdef SCAN_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic          tick_c;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next_c;
   logic          blank_c;
   row_t          row;
   row_t          row_next_c;
   logic          bank_sel;
   logic          bank_sel_next_c;
   logic          swap_c;
   logic          swap_en_c;
   commit_state_t state;
   commit_state_t state_next_c;
   rgb_row_t      bank [NUM_BANKS][NUM_ROWS];
   rgb_row_t      front_c;

   scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
      .CLK    (CLK),
      .reset  (reset),
      .tick_c (tick_c),
      .count  (count)
   );

   assign swap_c          = tick_c && (row == LAST_ROW);
   assign row_next_c      = tick_c ? row_t'(row + 3'd1) : row;
   assign bank_sel_next_c = swap_en_c ? ~bank_sel : bank_sel;
   assign count_next_c    = tick_c ? '0 : count + CW'(1);
   assign blank_c         = BLANK_EN && (count_next_c < CW'(BLANK_CYCLES));

   // Commit FSM state register
   always_ff @(posedge CLK) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next_c;
   end

   // A commit arriving on the swap cycle re-arms for the following frame
   always_comb begin
      state_next_c = state;
      swap_en_c    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (commit) state_next_c = S_PENDING;
         end
         S_PENDING: begin
            if (swap_c) begin
               swap_en_c    = 1'b1;
               state_next_c = commit ? S_PENDING : S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         row      <= '0;
         bank_sel <= 1'b0;
      end else begin
         row      <= row_next_c;
         bank_sel <= bank_sel_next_c;
      end
   end

   // Writes always target the current back bank
   always_ff @(posedge CLK) begin
      if (!reset) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            for (int j = 0; j < NUM_ROWS; j++) begin
               bank[i][j] <= '{r: COL_OFF, g: COL_OFF, b: COL_OFF};
            end
         end
      end else if (wr_en) begin
         bank[~bank_sel][wr_row] <= '{r: wr_r, g: wr_g, b: wr_b};
      end
   end

   // Forward a swap-cycle write so it shows in the first row of the new frame
   always_comb begin
      front_c = bank[bank_sel_next_c][row_next_c];
      if (wr_en && swap_en_c && (wr_row == row_next_c)) begin
         front_c = '{r: wr_r, g: wr_g, b: wr_b};
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         D_R         <= COL_OFF;
         D_G         <= COL_OFF;
         D_B         <= COL_OFF;
         COMM        <= {COMM_EN, 3'd0};
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         COMM        <= {COMM_EN, row_next_c};
         frame_start <= swap_c;
         busy        <= (state_next_c == S_PENDING);
         if (blank_c) begin
            D_R <= COL_OFF;
            D_G <= COL_OFF;
            D_B <= COL_OFF;
         end else begin
            D_R <= front_c.r;
            D_G <= front_c.g;
            D_B <= front_c.b;
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with SCAN_DIV=4, BLANK_CYCLES=1.
module tb_led_matrix_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_r, wr_g, wr_b;
   logic       commit;
   logic       busy, frame_start;
   logic [7:0] D_R, D_G, D_B;
   logic [3:0] COMM;

   int         k;
   int         checks;
   int         errors;
   logic       exp_busy;
   logic [7:0] disp_r [8];
   logic [7:0] disp_g [8];
   logic [7:0] disp_b [8];

`ifdef SCAN_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   led_matrix_scanner #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
      .CLK         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_row      (wr_row),
      .wr_r        (wr_r),
      .wr_g        (wr_g),
      .wr_b        (wr_b),
      .commit      (commit),
      .busy        (busy),
      .frame_start (frame_start),
      .D_R         (D_R),
      .D_G         (D_G),
      .D_B         (D_B),
      .COMM        (COMM)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic clear_disp();
      for (int i = 0; i < 8; i++) begin
         disp_r[i] = 8'hFF;
         disp_g[i] = 8'hFF;
         disp_b[i] = 8'hFF;
      end
   endtask

   // Advance one clock and check every output against the expected picture
   task automatic step();
      logic [2:0] rw;
      logic       blank;
      logic       fs;
      @(negedge clk);
      k++;
      rw    = 3'((k / 4) % 8);
      blank = BLANK_ON && ((k % 4) == 0);
      fs    = ((k % 32) == 0);
      check("COMM", {4'h0, COMM}, {4'h0, 1'b1, rw});
      check("frame_start", {7'd0, frame_start}, {7'd0, fs});
      check("busy", {7'd0, busy}, {7'd0, exp_busy});
      check("D_R", D_R, blank ? 8'hFF : disp_r[rw]);
      check("D_G", D_G, blank ? 8'hFF : disp_g[rw]);
      check("D_B", D_B, blank ? 8'hFF : disp_b[rw]);
   endtask

   task automatic run_to(input int t);
      while (k < t) step();
   endtask

   initial begin
      checks = 0; errors = 0; k = 0; exp_busy = 1'b0;
      reset = 1'b0; wr_en = 1'b0; wr_row = 3'd0; commit = 1'b0;
      wr_r = 8'hFF; wr_g = 8'hFF; wr_b = 8'hFF;
      clear_disp();

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_D_R", D_R, 8'hFF);
      check("rst_D_G", D_G, 8'hFF);
      check("rst_D_B", D_B, 8'hFF);
      check("rst_COMM", {4'h0, COMM}, 8'h08);
      check("rst_busy", {7'd0, busy}, 8'h00);
      check("rst_frame_start", {7'd0, frame_start}, 8'h00);
      reset = 1'b1;
      run_to(33);

      // Write row 2 red, then commit; swap lands at posedge 64
      wr_en = 1'b1; wr_row = 3'd2; wr_r = 8'h7F;
      step();
      wr_en = 1'b0; wr_r = 8'hFF;
      commit = 1'b1; exp_busy = 1'b1;
      step();
      commit = 1'b0;
      run_to(63);
      disp_r[2] = 8'h7F; exp_busy = 1'b0;
      step();
      run_to(72);
      check("row2_first", D_R, BLANK_ON ? 8'hFF : 8'h7F);
      step();
      check("row2_second", D_R, 8'h7F);
      check("row2_comm", {4'h0, COMM}, 8'h0A);
      run_to(96);

      // Uncommitted write to row 5 must stay invisible for three frames
      wr_en = 1'b1; wr_row = 3'd5; wr_r = 8'h00; wr_g = 8'h00; wr_b = 8'h00;
      step();
      wr_en = 1'b0; wr_r = 8'hFF; wr_g = 8'hFF; wr_b = 8'hFF;
      run_to(192);

      // Commit, then commit again on the swap cycle plus a row-0 write
      run_to(200);
      commit = 1'b1; exp_busy = 1'b1;
      step();
      commit = 1'b0;
      run_to(223);
      commit = 1'b1; wr_en = 1'b1; wr_row = 3'd0; wr_r = 8'h0F;
      clear_disp();
      disp_r[0] = 8'h0F;
      disp_r[5] = 8'h00; disp_g[5] = 8'h00; disp_b[5] = 8'h00;
      step();
      commit = 1'b0; wr_en = 1'b0; wr_r = 8'hFF;
      check("rearm_busy", {7'd0, busy}, 8'h01);
      run_to(255);
      clear_disp();
      disp_r[2] = 8'h7F; exp_busy = 1'b0;
      step();
      check("second_swap_busy", {7'd0, busy}, 8'h00);
      run_to(264);

      // Reset in the middle of a pending commit
      commit = 1'b1; exp_busy = 1'b1;
      step();
      commit = 1'b0;
      run_to(270);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_busy", {7'd0, busy}, 8'h00);
      check("midrst_D_R", D_R, 8'hFF);
      check("midrst_D_G", D_G, 8'hFF);
      check("midrst_D_B", D_B, 8'hFF);
      check("midrst_COMM", {4'h0, COMM}, 8'h08);
      check("midrst_frame_start", {7'd0, frame_start}, 8'h00);
      clear_disp();
      exp_busy = 1'b0; k = 0;
      reset = 1'b1;
      run_to(2);
      wr_en = 1'b1; wr_row = 3'd3; wr_r = 8'h3C; wr_g = 8'h3C; wr_b = 8'h3C;
      step();
      wr_en = 1'b0; wr_r = 8'hFF; wr_g = 8'hFF; wr_b = 8'hFF;
      run_to(80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
